taxi_dma_ram_rd_arb: RTL and testbench
======================================

Name: taxi_dma_ram_rd_arb

Overview:
- Shares one segmented DMA RAM read port among PORTS DMA clients.
- Each segment has its own independent round-robin arbiter for read commands.
- Each segment also has an in-order tag FIFO that steers read responses back to the client that issued the command.
- Sits between several DMA engines (e.g. PCIe write DMA, Ethernet TX DMA) and a single dual-port buffer RAM; it is the many-to-one counterpart of the DMA RAM demux.

Parameters:
- PORTS, 2: number of client ports; 2..16.
- SEGS, 2: number of RAM segments; each segment is arbitrated independently.
- SEG_ADDR_W, 10: per-segment word address width.
- SEG_DATA_W, 64: per-segment data width.
- FIFO_DEPTH, 16: maximum outstanding commands per segment; a power of 2, at least the RAM read latency plus 2.

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- s_rd_cmd_addr  in  PORTS*SEGS*SEG_ADDR_W  client command address, indexed [port][seg]
- s_rd_cmd_valid  in  PORTS*SEGS  client command valid
- s_rd_cmd_ready  out  PORTS*SEGS  client command accepted
- s_rd_resp_data  out  PORTS*SEGS*SEG_DATA_W  read data to client
- s_rd_resp_valid  out  PORTS*SEGS  response valid to client
- s_rd_resp_ready  in  PORTS*SEGS  client response ready
- m_rd_cmd_addr  out  SEGS*SEG_ADDR_W  command address to RAM
- m_rd_cmd_valid  out  SEGS  command valid to RAM
- m_rd_cmd_ready  in  SEGS  RAM accepts command
- m_rd_resp_data  in  SEGS*SEG_DATA_W  read data from RAM
- m_rd_resp_valid  in  SEGS  RAM response valid
- m_rd_resp_ready  out  SEGS  response ready to RAM

Behaviour:
- All segments behave identically and share no state; everything below is per segment.
- Reset values:
  - m_rd_cmd_valid=0, m_rd_cmd_addr=0.
  - Tag FIFO empty, count=0.
  - Round-robin pointer last_grant=PORTS-1, so port 0 has highest priority on the first decision.
  - All outputs derived from state are therefore 0 after reset.
- Command output register (cmd_reg) is "free" when m_rd_cmd_valid=0, or when m_rd_cmd_valid&&m_rd_cmd_ready in the same cycle.
- Grant rule in cycle N:
  - Conditions: cmd_reg is free, count<FIFO_DEPTH, and at least one s_rd_cmd_valid is set.
  - The winner is the first valid port searching upward from last_grant+1, modulo PORTS.
  - Winner sees s_rd_cmd_ready=1 in cycle N (combinational); all other ports see 0.
  - At the clock edge: cmd_reg is loaded with the winner's address, m_rd_cmd_valid is set, the winner index is pushed to the tag FIFO, and last_grant becomes the winner.
- Latency: command valid in cycle N produces m_rd_cmd_valid in cycle N+1. Sustained throughput is 1 command/cycle while m_rd_cmd_ready=1.
- cmd_reg holds its value until accepted; m_rd_cmd_addr is stable while valid&&!ready.
- If cmd_reg is free and no grant occurs, m_rd_cmd_valid clears.
- FIFO full: count==FIFO_DEPTH blocks grants even if a pop occurs in the same cycle. This is a registered decision, so there is no combinational path from resp to cmd.
- Response routing is combinational and uses the FIFO head index h:
  - s_rd_resp_valid[h][seg] = m_rd_resp_valid && !empty.
  - s_rd_resp_data of every port = m_rd_resp_data.
  - m_rd_resp_ready = s_rd_resp_ready[h][seg] && !empty.
  - Pop on m_rd_resp_valid && m_rd_resp_ready.
- Empty FIFO: m_rd_resp_ready=0 and no s_rd_resp_valid is asserted. The response is held; this is a protocol violation by the RAM.
- Push and pop in the same cycle: count is unchanged. Pointers wrap modulo FIFO_DEPTH.
- Responses return in command order per segment. A client never receives another client's data.
- Reset mid-operation clears all state at once. The RAM must be reset with this block, because in-flight responses are not drained.

Decomposition:
- Package taxi_dma_ram_pkg holds:
  - the clog2-based index width for PORTS;
  - the port/segment slicing helper functions.
- Sub-module taxi_dma_ram_rd_arb_seg contains one segment's arbiter, cmd_reg and tag FIFO. The top level is a generate loop over SEGS plus vector slicing.

Test Plan:
- After reset, ports 0 and 1 both request seg 0 with addresses 0x010/0x020 held valid → m_rd_cmd_addr sequence 0x010, 0x020, 0x010… (alternating, 1/cycle). Responses D0, D1 are delivered to port 0 then port 1.
- Single port 1 issues 3 commands back-to-back → m_rd_cmd_valid in cycles N+1..N+3. Port 0 sees no s_rd_resp_valid.
- m_rd_resp_valid=0 with 16 commands accepted → 17th command stalls with s_rd_cmd_ready=0. One response popped → stalled command granted the next cycle.
- m_rd_cmd_ready=0 for 5 cycles → m_rd_cmd_addr/valid stable and no further grants. Ready=1 → drains one per cycle.
- Head owner (port 0) holds s_rd_resp_ready=0 → m_rd_resp_ready=0, and port 1's later response waits (in-order).
- Segments 0 and 1 loaded concurrently with different winners → independent orderings. Reset asserted mid-burst → count=0 and m_rd_cmd_valid=0 immediately (asynchronous).

Source files
------------

// File: rtl/taxi_dma_ram_pkg.sv
// Shared helpers for the DMA RAM read arbiter.
// Index widths and [port][seg] flat-vector slicing.
package taxi_dma_ram_pkg;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int lane(input int port, input int seg, input int segs);
    return port * segs + seg;
  endfunction

  function automatic int lsb(input int port, input int seg,
                             input int segs, input int w);
    return lane(port, seg, segs) * w;
  endfunction

endpackage

// File: rtl/taxi_dma_ram_rd_arb_seg.sv
// One RAM segment: round-robin command arbiter, command register and
// in-order tag FIFO steering read responses back to the issuing port.
module taxi_dma_ram_rd_arb_seg
  import taxi_dma_ram_pkg::*;
#(
  parameter int PORTS      = 2,
  parameter int SEG_ADDR_W = 10,
  parameter int SEG_DATA_W = 64,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [PORTS*SEG_ADDR_W-1:0] cmd_addr,
  input  logic [PORTS-1:0]            cmd_valid,
  output logic [PORTS-1:0]            cmd_ready,
  output logic [PORTS*SEG_DATA_W-1:0] resp_data,
  output logic [PORTS-1:0]            resp_valid,
  input  logic [PORTS-1:0]            resp_ready,
  output logic [SEG_ADDR_W-1:0]       m_cmd_addr,
  output logic                        m_cmd_valid,
  input  logic                        m_cmd_ready,
  input  logic [SEG_DATA_W-1:0]       m_resp_data,
  input  logic                        m_resp_valid,
  output logic                        m_resp_ready
);

  localparam int IW = idx_w(PORTS);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  logic [IW-1:0] last_grant;
  logic [IW-1:0] winner;
  logic [IW-1:0] head;
  logic          found;
  logic          free;
  logic          full;
  logic          empty;
  logic          grant;
  logic          pop;

  logic [IW-1:0] tag_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;

  // First requester strictly after the previous winner, wrapping.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    for (int i = 1; i <= PORTS; i++) begin
      if (!found && cmd_valid[(int'(last_grant) + i) % PORTS]) begin
        found  = 1'b1;
        winner = IW'((int'(last_grant) + i) % PORTS);
      end
    end
  end

  assign free  = !m_cmd_valid || m_cmd_ready;
  assign full  = (count == CW'(FIFO_DEPTH));
  assign empty = (count == '0);
  assign grant = free && !full && found;
  assign head  = tag_mem[rd_ptr];

  assign m_resp_ready = !empty && resp_ready[head];
  assign pop          = m_resp_valid && m_resp_ready;
  assign resp_data    = {PORTS{m_resp_data}};

  always_comb begin
    cmd_ready  = '0;
    resp_valid = '0;
    if (grant) cmd_ready[winner] = 1'b1;
    if (!empty) resp_valid[head] = m_resp_valid;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_cmd_addr  <= '0;
      m_cmd_valid <= 1'b0;
      last_grant  <= IW'(PORTS - 1);
    end else if (free) begin
      m_cmd_valid <= grant;
      if (grant) begin
        m_cmd_addr <= cmd_addr[int'(winner)*SEG_ADDR_W +: SEG_ADDR_W];
        last_grant <= winner;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (grant) tag_mem[wr_ptr] <= winner;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (grant) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (grant && !pop) count <= count + 1'b1;
      else if (!grant && pop) count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/taxi_dma_ram_rd_arb.sv
// Segmented DMA RAM read-port arbiter: PORTS clients share one RAM,
// each segment arbitrated and response-routed independently.
module taxi_dma_ram_rd_arb
  import taxi_dma_ram_pkg::*;
#(
  parameter int PORTS      = 2,
  parameter int SEGS       = 2,
  parameter int SEG_ADDR_W = 10,
  parameter int SEG_DATA_W = 64,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [PORTS*SEGS*SEG_ADDR_W-1:0] s_rd_cmd_addr,
  input  logic [PORTS*SEGS-1:0]            s_rd_cmd_valid,
  output logic [PORTS*SEGS-1:0]            s_rd_cmd_ready,
  output logic [PORTS*SEGS*SEG_DATA_W-1:0] s_rd_resp_data,
  output logic [PORTS*SEGS-1:0]            s_rd_resp_valid,
  input  logic [PORTS*SEGS-1:0]            s_rd_resp_ready,
  output logic [SEGS*SEG_ADDR_W-1:0]       m_rd_cmd_addr,
  output logic [SEGS-1:0]                  m_rd_cmd_valid,
  input  logic [SEGS-1:0]                  m_rd_cmd_ready,
  input  logic [SEGS*SEG_DATA_W-1:0]       m_rd_resp_data,
  input  logic [SEGS-1:0]                  m_rd_resp_valid,
  output logic [SEGS-1:0]                  m_rd_resp_ready
);

  for (genvar s = 0; s < SEGS; s++) begin : g_seg
    logic [PORTS*SEG_ADDR_W-1:0] c_addr;
    logic [PORTS-1:0]            c_valid;
    logic [PORTS-1:0]            c_ready;
    logic [PORTS*SEG_DATA_W-1:0] r_data;
    logic [PORTS-1:0]            r_valid;
    logic [PORTS-1:0]            r_ready;

    for (genvar p = 0; p < PORTS; p++) begin : g_port
      assign c_addr[p*SEG_ADDR_W +: SEG_ADDR_W] =
        s_rd_cmd_addr[lsb(p, s, SEGS, SEG_ADDR_W) +: SEG_ADDR_W];
      assign c_valid[p] = s_rd_cmd_valid[lane(p, s, SEGS)];
      assign r_ready[p] = s_rd_resp_ready[lane(p, s, SEGS)];
      assign s_rd_cmd_ready[lane(p, s, SEGS)]  = c_ready[p];
      assign s_rd_resp_valid[lane(p, s, SEGS)] = r_valid[p];
      assign s_rd_resp_data[lsb(p, s, SEGS, SEG_DATA_W) +: SEG_DATA_W] =
        r_data[p*SEG_DATA_W +: SEG_DATA_W];
    end

    taxi_dma_ram_rd_arb_seg #(
      .PORTS      (PORTS),
      .SEG_ADDR_W (SEG_ADDR_W),
      .SEG_DATA_W (SEG_DATA_W),
      .FIFO_DEPTH (FIFO_DEPTH)
    ) u_seg (
      .clk          (clk),
      .rst          (rst),
      .cmd_addr     (c_addr),
      .cmd_valid    (c_valid),
      .cmd_ready    (c_ready),
      .resp_data    (r_data),
      .resp_valid   (r_valid),
      .resp_ready   (r_ready),
      .m_cmd_addr   (m_rd_cmd_addr[s*SEG_ADDR_W +: SEG_ADDR_W]),
      .m_cmd_valid  (m_rd_cmd_valid[s]),
      .m_cmd_ready  (m_rd_cmd_ready[s]),
      .m_resp_data  (m_rd_resp_data[s*SEG_DATA_W +: SEG_DATA_W]),
      .m_resp_valid (m_rd_resp_valid[s]),
      .m_resp_ready (m_rd_resp_ready[s])
    );
  end

endmodule

// File: tb/tb_taxi_dma_ram_rd_arb.sv
// Directed self-checking bench for taxi_dma_ram_rd_arb.
// PORTS=2, SEGS=2; lane index for [port][seg] is port*2+seg.
module tb_taxi_dma_ram_rd_arb;

  localparam int P  = 2;
  localparam int S  = 2;
  localparam int AW = 10;
  localparam int DW = 64;
  localparam int FD = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic [P*S*AW-1:0] s_rd_cmd_addr;
  logic [P*S-1:0]    s_rd_cmd_valid;
  logic [P*S-1:0]    s_rd_cmd_ready;
  logic [P*S*DW-1:0] s_rd_resp_data;
  logic [P*S-1:0]    s_rd_resp_valid;
  logic [P*S-1:0]    s_rd_resp_ready;
  logic [S*AW-1:0]   m_rd_cmd_addr;
  logic [S-1:0]      m_rd_cmd_valid;
  logic [S-1:0]      m_rd_cmd_ready;
  logic [S*DW-1:0]   m_rd_resp_data;
  logic [S-1:0]      m_rd_resp_valid;
  logic [S-1:0]      m_rd_resp_ready;

  int compared   = 0;
  int mismatched = 0;

  taxi_dma_ram_rd_arb #(
    .PORTS(P), .SEGS(S), .SEG_ADDR_W(AW), .SEG_DATA_W(DW), .FIFO_DEPTH(FD)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .s_rd_cmd_addr   (s_rd_cmd_addr),
    .s_rd_cmd_valid  (s_rd_cmd_valid),
    .s_rd_cmd_ready  (s_rd_cmd_ready),
    .s_rd_resp_data  (s_rd_resp_data),
    .s_rd_resp_valid (s_rd_resp_valid),
    .s_rd_resp_ready (s_rd_resp_ready),
    .m_rd_cmd_addr   (m_rd_cmd_addr),
    .m_rd_cmd_valid  (m_rd_cmd_valid),
    .m_rd_cmd_ready  (m_rd_cmd_ready),
    .m_rd_resp_data  (m_rd_resp_data),
    .m_rd_resp_valid (m_rd_resp_valid),
    .m_rd_resp_ready (m_rd_resp_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic setc(input int p, input int s, input logic [AW-1:0] a,
                      input logic v);
    s_rd_cmd_addr[(p*S+s)*AW +: AW] = a;
    s_rd_cmd_valid[p*S+s] = v;
  endtask

  initial begin
    rst             = 1'b1;
    s_rd_cmd_addr   = '0;
    s_rd_cmd_valid  = '0;
    s_rd_resp_ready = '1;
    m_rd_cmd_ready  = '1;
    m_rd_resp_data  = '0;
    m_rd_resp_valid = '0;

    // reset state
    tick();
    chk("rst_cmd_valid", 64'(m_rd_cmd_valid), 64'h0);
    chk("rst_cmd_addr", 64'(m_rd_cmd_addr), 64'h0);
    chk("rst_resp_valid", 64'(s_rd_resp_valid), 64'h0);
    chk("rst_resp_ready", 64'(m_rd_resp_ready), 64'h0);
    rst = 1'b0;

    // two ports on seg0 alternate, port 0 first
    setc(0, 0, 10'h010, 1'b1);
    setc(1, 0, 10'h020, 1'b1);
    settle();
    chk("rr_ready0", 64'(s_rd_cmd_ready), 64'h1);
    tick();
    chk("rr_addr0", 64'(m_rd_cmd_addr[9:0]), 64'h010);
    chk("rr_valid0", 64'(m_rd_cmd_valid[0]), 64'h1);
    chk("rr_ready1", 64'(s_rd_cmd_ready), 64'h4);
    tick();
    chk("rr_addr1", 64'(m_rd_cmd_addr[9:0]), 64'h020);
    tick();
    chk("rr_addr2", 64'(m_rd_cmd_addr[9:0]), 64'h010);
    setc(0, 0, 10'h0, 1'b0);
    setc(1, 0, 10'h0, 1'b0);
    tick();
    chk("rr_idle", 64'(m_rd_cmd_valid[0]), 64'h0);
    // responses return to ports 0, 1, 0
    m_rd_resp_valid[0] = 1'b1;
    m_rd_resp_data[63:0] = 64'hD0;
    settle();
    chk("rsp0_valid", 64'(s_rd_resp_valid), 64'h1);
    chk("rsp0_data", s_rd_resp_data[63:0], 64'hD0);
    chk("rsp0_mready", 64'(m_rd_resp_ready), 64'h1);
    tick();
    m_rd_resp_data[63:0] = 64'hD1;
    settle();
    chk("rsp1_valid", 64'(s_rd_resp_valid), 64'h4);
    chk("rsp1_data", s_rd_resp_data[2*DW +: DW], 64'hD1);
    tick();
    m_rd_resp_data[63:0] = 64'hD2;
    settle();
    chk("rsp2_valid", 64'(s_rd_resp_valid), 64'h1);
    tick();
    chk("empty_mready", 64'(m_rd_resp_ready), 64'h0);
    chk("empty_svalid", 64'(s_rd_resp_valid), 64'h0);
    m_rd_resp_valid = '0;

    // single port 1: three back-to-back commands
    setc(1, 0, 10'h100, 1'b1);
    settle();
    chk("p1_ready", 64'(s_rd_cmd_ready), 64'h4);
    tick();
    chk("p1_addr0", 64'(m_rd_cmd_addr[9:0]), 64'h100);
    setc(1, 0, 10'h101, 1'b1);
    tick();
    chk("p1_addr1", 64'(m_rd_cmd_addr[9:0]), 64'h101);
    chk("p1_valid1", 64'(m_rd_cmd_valid[0]), 64'h1);
    setc(1, 0, 10'h102, 1'b1);
    tick();
    chk("p1_addr2", 64'(m_rd_cmd_addr[9:0]), 64'h102);
    setc(1, 0, 10'h0, 1'b0);
    tick();
    chk("p1_idle", 64'(m_rd_cmd_valid[0]), 64'h0);
    m_rd_resp_valid[0] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      m_rd_resp_data[63:0] = 64'(k + 'h50);
      settle();
      chk("p1_rsp_valid", 64'(s_rd_resp_valid), 64'h4);
      chk("p1_rsp_data", s_rd_resp_data[2*DW +: DW], 64'(k + 'h50));
      tick();
    end
    m_rd_resp_valid = '0;

    // fill the tag FIFO, then release one entry
    for (int i = 0; i < FD; i++) begin
      setc(0, 0, AW'(i), 1'b1);
      settle();
      chk("fill_ready", 64'(s_rd_cmd_ready[0]), 64'h1);
      tick();
    end
    setc(0, 0, AW'(FD), 1'b1);
    settle();
    chk("full_block", 64'(s_rd_cmd_ready[0]), 64'h0);
    tick();
    chk("full_cmd_idle", 64'(m_rd_cmd_valid[0]), 64'h0);
    m_rd_resp_valid[0] = 1'b1;
    settle();
    chk("full_pop_ready", 64'(m_rd_resp_ready[0]), 64'h1);
    chk("full_same_cycle", 64'(s_rd_cmd_ready[0]), 64'h0);
    tick();
    m_rd_resp_valid = '0;
    settle();
    chk("after_pop_ready", 64'(s_rd_cmd_ready[0]), 64'h1);
    tick();
    chk("stall_granted", 64'(m_rd_cmd_valid[0]), 64'h1);
    chk("stall_addr", 64'(m_rd_cmd_addr[9:0]), 64'(FD));
    setc(0, 0, 10'h0, 1'b0);
    m_rd_resp_valid[0] = 1'b1;
    repeat (FD) tick();
    chk("drained", 64'(m_rd_resp_ready[0]), 64'h0);
    m_rd_resp_valid = '0;

    // RAM back-pressure holds the command register
    m_rd_cmd_ready[0] = 1'b0;
    setc(0, 0, 10'h055, 1'b1);
    tick();
    setc(0, 0, 10'h066, 1'b1);
    for (int i = 0; i < 5; i++) begin
      settle();
      chk("hold_addr", 64'(m_rd_cmd_addr[9:0]), 64'h055);
      chk("hold_valid", 64'(m_rd_cmd_valid[0]), 64'h1);
      chk("hold_no_grant", 64'(s_rd_cmd_ready[0]), 64'h0);
      tick();
    end
    m_rd_cmd_ready[0] = 1'b1;
    settle();
    chk("hold_release", 64'(s_rd_cmd_ready[0]), 64'h1);
    tick();
    chk("hold_next", 64'(m_rd_cmd_addr[9:0]), 64'h066);
    setc(0, 0, 10'h0, 1'b0);
    m_rd_resp_valid[0] = 1'b1;
    tick();
    tick();
    m_rd_resp_valid = '0;
    settle();
    chk("hold_drained", 64'(m_rd_resp_ready[0]), 64'h0);

    // head owner back-pressure blocks later responses
    setc(0, 0, 10'h0AA, 1'b1);
    tick();
    setc(0, 0, 10'h0, 1'b0);
    setc(1, 0, 10'h0BB, 1'b1);
    tick();
    setc(1, 0, 10'h0, 1'b0);
    tick();
    s_rd_resp_ready[0] = 1'b0;
    m_rd_resp_valid[0] = 1'b1;
    settle();
    chk("hol_mready", 64'(m_rd_resp_ready[0]), 64'h0);
    chk("hol_svalid", 64'(s_rd_resp_valid), 64'h1);
    tick();
    chk("hol_still", 64'(s_rd_resp_valid), 64'h1);
    s_rd_resp_ready[0] = 1'b1;
    settle();
    chk("hol_go", 64'(m_rd_resp_ready[0]), 64'h1);
    tick();
    chk("hol_p1", 64'(s_rd_resp_valid), 64'h4);
    tick();
    m_rd_resp_valid = '0;

    // independent segments; seg0 last winner is port 0
    setc(0, 0, 10'h1FF, 1'b1);
    tick();
    setc(0, 0, 10'h200, 1'b1);
    setc(0, 1, 10'h201, 1'b1);
    setc(1, 0, 10'h210, 1'b1);
    setc(1, 1, 10'h211, 1'b1);
    settle();
    chk("seg_ready0", 64'(s_rd_cmd_ready), 64'h6);
    tick();
    chk("seg_addr0", 64'(m_rd_cmd_addr), 64'({10'h201, 10'h210}));
    chk("seg_ready1", 64'(s_rd_cmd_ready), 64'h9);
    tick();
    chk("seg_addr1", 64'(m_rd_cmd_addr), 64'({10'h211, 10'h200}));
    chk("seg_valid", 64'(m_rd_cmd_valid), 64'h3);

    // asynchronous reset mid-burst
    #2;
    rst = 1'b1;
    m_rd_resp_valid = '1;
    settle();
    chk("arst_cmd_valid", 64'(m_rd_cmd_valid), 64'h0);
    chk("arst_empty", 64'(m_rd_resp_ready), 64'h0);
    chk("arst_svalid", 64'(s_rd_resp_valid), 64'h0);
    tick();
    m_rd_resp_valid = '0;
    rst = 1'b0;
    s_rd_cmd_valid = '0;
    setc(0, 0, 10'h300, 1'b1);
    setc(1, 0, 10'h310, 1'b1);
    settle();
    chk("post_rst_prio", 64'(s_rd_cmd_ready), 64'h1);
    tick();
    chk("post_rst_addr", 64'(m_rd_cmd_addr[9:0]), 64'h300);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
